// File: rtl/line_mem_responder.sv
// rtl/line_mem_responder.sv - single-port 128-bit line memory responder with fixed read/write latency
//
// Ports:
//   clk              in   1    clock, rising edge
//   rst              in   1    synchronous active-high reset
//   i_addr           in   32   byte address; line index = i_addr[LINE_IDX_W+3:4], other bits ignored
//   i_byte_en        in   4    per-32-bit-word write enable (bit k -> bits [32k+31:32k])
//   i_writedata      in   128  write line data
//   i_read           in   1    line read request
//   i_write          in   1    line write request (wins over i_read when both are high)
//   o_readdata       out  128  read line data, holds last returned line
//   o_readdata_valid out  1    one-cycle pulse READ_LATENCY cycles after read acceptance
//   o_waitrequest    out  1    registered busy flag

module line_mem_responder #(
    parameter int LINE_IDX_W    = 10,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  i_addr,
    input  logic [3:0]   i_byte_en,
    input  logic [127:0] i_writedata,
    input  logic         i_read,
    input  logic         i_write,
    output logic [127:0] o_readdata,
    output logic         o_readdata_valid,
    output logic         o_waitrequest
);

    localparam int DEPTH = 1 << LINE_IDX_W;
    localparam logic [3:0] RD_INIT = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_INIT = 4'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            cnt;
    logic [3:0]            cnt_nxt;
    logic [LINE_IDX_W-1:0] req_idx;
    logic [LINE_IDX_W-1:0] rd_idx;
    logic [LINE_IDX_W-1:0] rd_src_idx;
    logic                  accept_rd;
    logic                  accept_wr;
    logic                  fire;

    logic [127:0] mem [0:DEPTH-1];

    // Offset bits and the bits above the index are don't-care: upper addresses alias.
    assign req_idx = i_addr[LINE_IDX_W+3:4];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[3:0], i_addr[31:LINE_IDX_W+4]};

    // With READ_LATENCY = 1 the response is launched straight from the request
    // index in the acceptance cycle; otherwise from the latched index.
    assign rd_src_idx = (state == IDLE) ? req_idx : rd_idx;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept_rd = 1'b0;
        accept_wr = 1'b0;
        fire      = 1'b0;
        case (state)
            IDLE: begin
                if ((i_read || i_write) && !o_waitrequest) begin
                    if (i_write) begin
                        accept_wr = 1'b1;
                        state_nxt = WR_WAIT;
                        cnt_nxt   = WR_INIT;
                    end else begin
                        accept_rd = 1'b1;
                        state_nxt = RD_WAIT;
                        cnt_nxt   = RD_INIT;
                        fire      = (READ_LATENCY == 1);
                    end
                end
            end
            RD_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    // Outputs are registered, so the pulse is launched one
                    // cycle before the counter reaches zero.
                    fire    = (cnt == 4'd1);
                end
            end
            WR_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= 4'd0;
            rd_idx           <= '0;
            o_waitrequest    <= 1'b0;
            o_readdata_valid <= 1'b0;
            o_readdata       <= '0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            o_waitrequest    <= (state_nxt != IDLE);
            o_readdata_valid <= fire;
            if (accept_rd) begin
                rd_idx <= req_idx;
            end
            if (fire) begin
                o_readdata <= mem[rd_src_idx];
            end
        end
    end

    // Storage is never cleared; writes commit at the acceptance edge.
    always_ff @(posedge clk) begin
        if (!rst && accept_wr) begin
            for (int k = 0; k < 4; k++) begin
                if (i_byte_en[k]) begin
                    mem[req_idx][32*k +: 32] <= i_writedata[32*k +: 32];
                end
            end
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// tb/tb_line_mem_responder.sv - self-checking bench for line_mem_responder against a cycle-count model

module tb_line_mem_responder;

    localparam int IDX_W = 10;
    localparam int RL    = 4;
    localparam int WL    = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic [3:0]   be;
    logic [127:0] wd;
    logic         rd;
    logic         wr;
    logic [127:0] rdata;
    logic         rvalid;
    logic         wreq;

    line_mem_responder #(
        .LINE_IDX_W   (IDX_W),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_addr          (addr),
        .i_byte_en       (be),
        .i_writedata     (wd),
        .i_read          (rd),
        .i_write         (wr),
        .o_readdata      (rdata),
        .o_readdata_valid(rvalid),
        .o_waitrequest   (wreq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vcount = 0;

    // Model: current cycle number, last cycle the responder is busy, cycle of
    // the pending read pulse, and a plain array image of memory.
    int           cyc      = 0;
    int           busy_end = -1;
    int           rd_due   = -1;
    logic [127:0] rd_data  = '0;
    logic [127:0] mm [0:(1<<IDX_W)-1];
    logic         exp_wait;
    logic         exp_valid;
    logic [127:0] exp_data;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 4) % (32'd1 << IDX_W));
    endfunction

    task automatic model_step(input logic r, input logic rq, input logic wq,
                              input logic [31:0] a, input logic [3:0] b, input logic [127:0] d);
        int idx;
        if (r) begin
            busy_end = cyc;
            rd_due   = -1;
            exp_data = '0;
        end else if ((rq || wq) && cyc > busy_end) begin
            idx = line_of(a);
            if (wq) begin
                for (int k = 0; k < 4; k++)
                    if (b[k]) mm[idx][32*k +: 32] = d[32*k +: 32];
                busy_end = cyc + WL;
            end else begin
                rd_data  = mm[idx];
                rd_due   = cyc + RL;
                busy_end = cyc + RL;
            end
        end
        cyc++;
        exp_wait  = (cyc <= busy_end);
        exp_valid = (cyc == rd_due);
        if (exp_valid) exp_data = rd_data;
    endtask

    task automatic compare();
        chk("waitrequest", {127'd0, wreq}, {127'd0, exp_wait});
        chk("readdata_valid", {127'd0, rvalid}, {127'd0, exp_valid});
        chk("readdata", rdata, exp_data);
    endtask

    task automatic step(input logic r, input logic rq, input logic wq,
                        input logic [31:0] a, input logic [3:0] b, input logic [127:0] d);
        rst  = r;
        rd   = rq;
        wr   = wq;
        addr = a;
        be   = b;
        wd   = d;
        model_step(r, rq, wq, a, b, d);
        @(posedge clk);
        #1;
        compare();
        if (rvalid === 1'b1) vcount++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 128'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] b, input logic [127:0] d);
        step(1'b0, 1'b0, 1'b1, a, b, d);
        repeat (WL) idle();
    endtask

    task automatic do_read_check(input string name, input logic [31:0] a, input logic [127:0] exp);
        step(1'b0, 1'b1, 1'b0, a, 4'd0, 128'd0);
        chk({name, "_wait_c1"}, {127'd0, wreq}, 128'd1);
        idle();
        idle();
        idle();
        chk({name, "_valid_c4"}, {127'd0, rvalid}, 128'd1);
        chk({name, "_data"}, rdata, exp);
        idle();
        chk({name, "_wait_c5"}, {127'd0, wreq}, 128'd0);
        chk({name, "_valid_c5"}, {127'd0, rvalid}, 128'd0);
    endtask

    localparam logic [127:0] D_BASIC = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [127:0] D_PART  = 128'hAAAAAAAA_55555555_AAAAAAAA_55555555;

    int lines [8] = '{'h004, 'h010, 'h001, 'h020, 'h3FF, 'h155, 'h2AA, 'h0FF};

    initial begin
        int v0;
        logic [31:0]  ra;
        logic [127:0] rdd;

        for (int i = 0; i < (1 << IDX_W); i++) mm[i] = '0;
        exp_data = '0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 128'd0);
        step(1'b1, 1'b1, 1'b1, 32'h40, 4'hF, 128'd0);
        chk("reset_wait", {127'd0, wreq}, 128'd0);
        chk("reset_valid", {127'd0, rvalid}, 128'd0);
        chk("reset_data", rdata, 128'd0);

        // Basic read latency
        do_write(32'h0000_0040, 4'hF, D_BASIC);
        do_read_check("basic", 32'h0000_0040, D_BASIC);

        // Partial write
        do_write(32'h0000_0100, 4'hF, {4{32'hAAAAAAAA}});
        do_write(32'h0000_0100, 4'b0101, {4{32'h55555555}});
        do_read_check("partial", 32'h0000_0100, D_PART);

        // Busy drop: write to another line in cycle 2 of a read is ignored
        v0 = vcount;
        step(1'b0, 1'b1, 1'b0, 32'h40, 4'd0, 128'd0);
        idle();
        step(1'b0, 1'b0, 1'b1, 32'h100, 4'hF, {4{32'hFFFFFFFF}});
        repeat (4) idle();
        chk("busy_drop_pulses", 128'(vcount - v0), 128'd1);
        do_read_check("busy_drop_line", 32'h0000_0100, D_PART);

        // Aliasing and offset
        do_write(32'h0000_0010, 4'hF, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);
        do_read_check("alias", 32'h0000_401C, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);

        // Simultaneous read and write is a write
        v0 = vcount;
        step(1'b0, 1'b1, 1'b1, 32'h200, 4'hF, 128'h11112222_33334444_55556666_77778888);
        chk("simul_wait_c1", {127'd0, wreq}, 128'd1);
        idle();
        chk("simul_wait_c2", {127'd0, wreq}, 128'd1);
        idle();
        chk("simul_wait_c3", {127'd0, wreq}, 128'd0);
        repeat (4) idle();
        chk("simul_no_pulse", 128'(vcount - v0), 128'd0);
        do_read_check("simul_data", 32'h200, 128'h11112222_33334444_55556666_77778888);

        // Reset mid-read
        v0 = vcount;
        step(1'b0, 1'b1, 1'b0, 32'h40, 4'd0, 128'd0);
        idle();
        step(1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 128'd0);
        chk("rst_mid_wait", {127'd0, wreq}, 128'd0);
        repeat (5) idle();
        chk("rst_mid_no_pulse", 128'(vcount - v0), 128'd0);
        do_read_check("after_rst", 32'h200, 128'h11112222_33334444_55556666_77778888);

        // Prefill the randomly exercised lines so every read is defined
        foreach (lines[i]) begin
            rdd = {$urandom(), $urandom(), $urandom(), $urandom()};
            do_write(32'(lines[i]) << 4, 4'hF, rdd);
        end

        // Random traffic, including requests while busy and occasional resets
        for (int n = 0; n < 3000; n++) begin
            ra  = ($urandom() & 32'hFFFF_C00F) | (32'(lines[$urandom_range(0, 7)]) << 4);
            rdd = {$urandom(), $urandom(), $urandom(), $urandom()};
            step($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 ra, 4'($urandom_range(0, 15)), rdd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
